pwm_multi: RTL

Multi-channel, parametrised PWM generator. It succeeds the single-channel 4-bit PWM and adds:
- configurable width and channel count;
- a clock prescaler;
- a runtime-programmable period;
- edge- or center-aligned counting;
- double-buffered duty registers that update glitch-free at period boundaries.

It sits between the user-IO input pins (configuration and duty writes) and the LED/output pins.

---
 rtl/pwm_multi.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaler and edge/center-aligned counter,
// per-channel double-buffered duty registers that swap glitch-free at each wrap.
module pwm_multi #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int PRESC_W  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        center_mode,
   input  logic [PRESC_W-1:0]          prescale,
   input  logic [WIDTH-1:0]            period,
   input  logic                        duty_wr,
   input  logic [$clog2(CHANNELS)-1:0] duty_sel,
   input  logic [WIDTH-1:0]            duty_data,
   output logic [CHANNELS-1:0]         pwm_out,
   output logic                        cycle_start,
   output logic [WIDTH-1:0]            count
);

   localparam logic [WIDTH-1:0]   CNT_ONE   = WIDTH'(1);
   localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

   // Counter direction is the only FSM state; it is observable as dir_q.
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   logic [PRESC_W-1:0] presc_q;
   logic [WIDTH-1:0]   count_q;
   logic [WIDTH-1:0]   count_nxt;
   dir_t               dir_q;
   dir_t               dir_nxt;
   logic               mode_q;
   logic               cs_q;
   logic               tick;
   logic               wrap;

   logic [WIDTH-1:0]   shadow_q   [CHANNELS];
   logic [WIDTH-1:0]   shadow_nxt [CHANNELS];
   logic [WIDTH-1:0]   active_q   [CHANNELS];

   // Using >= lets a runtime prescale reduction take effect without a full rollover.
   assign tick = en && (presc_q >= prescale);

   always_comb begin
      count_nxt = count_q;
      dir_nxt   = dir_q;
      if (!mode_q) begin
         count_nxt = (count_q >= period) ? '0 : count_q + CNT_ONE;
         dir_nxt   = DIR_UP;
      end else if (dir_q == DIR_UP) begin
         if (count_q >= period) begin
            count_nxt = (count_q == '0) ? '0 : count_q - CNT_ONE;
            dir_nxt   = DIR_DOWN;
         end else begin
            count_nxt = count_q + CNT_ONE;
         end
      end else begin
         count_nxt = count_q - CNT_ONE;
      end
      // Reaching zero always ends a center-aligned period and restarts upward.
      if (count_nxt == '0) begin
         dir_nxt = DIR_UP;
      end
   end

   assign wrap = tick && (count_nxt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         count_q <= '0;
         dir_q   <= DIR_UP;
         mode_q  <= 1'b0;
         cs_q    <= 1'b0;
      end else if (!en) begin
         presc_q <= '0;
         count_q <= '0;
         dir_q   <= DIR_UP;
         mode_q  <= center_mode;
         cs_q    <= 1'b0;
      end else begin
         presc_q <= tick ? '0 : presc_q + PRESC_ONE;
         if (tick) begin
            count_q <= count_nxt;
            dir_q   <= dir_nxt;
         end
         cs_q <= wrap;
      end
   end

   // duty_wr is a one-cycle strobe with no back-pressure: every asserted cycle is
   // accepted, and a write coinciding with a wrap is forwarded into the active copy.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         shadow_nxt[i] = (duty_wr && (int'(duty_sel) == i)) ? duty_data : shadow_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= shadow_nxt[i];
            if (!en || wrap) begin
               active_q[i] <= shadow_nxt[i];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_out[i] = en && (count_q < active_q[i]);
      end
   end

   assign cycle_start = cs_q;
   assign count       = count_q;

endmodule
